// File: rtl/sync_level_filter.sv
// ---------------------------------------------------------------------------
// SyncLevelFilter (module sync_level_filter)
//
// Purpose:
//   Sits directly downstream of a two-flop synchronizer. It removes short
//   glitches from the synchronized level. A level change is accepted only
//   after FILT_CYCLES consecutive identical samples. The block then produces
//   a filtered level, single-cycle rise/fall pulses, a sticky event-pending
//   flag with acknowledge, and a saturating count of accepted rising edges.
//
// Parameters:
//   FILT_CYCLES  consecutive samples needed to accept a level change (1..255)
//   CNT_W        width of the rising-event counter (>= 1)
//
// Ports:
//   clk            in   single clock; all logic runs on its rising edge
//   rstn           in   asynchronous active-low reset, released on clk
//   din            in   synchronized level from the upstream synchronizer
//   clr_cnt        in   synchronous clear of evt_cnt_o and cnt_sat_o
//   evt_ack        in   synchronous clear of evt_pending_o
//   lvl_o          out  filtered level
//   rise_o         out  one-cycle pulse in the first cycle lvl_o reads 1
//   fall_o         out  one-cycle pulse in the first cycle lvl_o reads 0
//   evt_pending_o  out  sticky flag, set on any accepted edge
//   evt_cnt_o      out  saturating count of accepted rising edges
//   cnt_sat_o      out  sticky flag, set once the counter reaches all-ones
// ---------------------------------------------------------------------------
module sync_level_filter #(
    parameter int unsigned FILT_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             din,
    input  logic             clr_cnt,
    input  logic             evt_ack,
    output logic             lvl_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             evt_pending_o,
    output logic [CNT_W-1:0] evt_cnt_o,
    output logic             cnt_sat_o
);

    // The filter counter must be able to hold FILT_CYCLES itself, because the
    // accept decision compares the incremented count against that value.
    localparam int unsigned        FCNT_W      = $clog2(FILT_CYCLES + 1);
    localparam logic [FCNT_W-1:0]  FCNT_TARGET = FCNT_W'(FILT_CYCLES);
    localparam logic [FCNT_W-1:0]  FCNT_ONE    = FCNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_MAX     = '1;
    localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHK_HI    = 2'd1,
        STABLE_HI = 2'd2,
        CHK_LO    = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic [FCNT_W-1:0]  r_fcnt;
    logic [FCNT_W-1:0]  w_nextFcnt;
    logic [FCNT_W-1:0]  w_fcntInc;
    logic               w_riseSet;
    logic               w_fallSet;

    logic               r_lvl;
    logic               r_rise;
    logic               r_fall;
    logic               r_pending;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cntInc;
    logic               r_sat;

    assign w_fcntInc = r_fcnt + FCNT_ONE;
    assign w_cntInc  = r_cnt + CNT_ONE;

    // State and filter-count register. Reset discards any partial filter
    // run, so a level already high at release is treated as a fresh edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= STABLE_LO;
            r_fcnt  <= '0;
        end else begin
            r_state <= w_nextState;
            r_fcnt  <= w_nextFcnt;
        end
    end

    // Next-state logic. A stable state starts a check run on the first
    // opposite sample; a check state either aborts back to its stable state
    // (glitch rejected, no output change) or accepts once the run length
    // reaches FILT_CYCLES. Only an accepted change raises w_riseSet or
    // w_fallSet, so returning from a rejected check never produces a pulse.
    always_comb begin
        w_nextState = r_state;
        w_nextFcnt  = r_fcnt;
        w_riseSet   = 1'b0;
        w_fallSet   = 1'b0;
        case (r_state)
            STABLE_LO: begin
                if (din) begin
                    w_nextFcnt = FCNT_ONE;
                    if (FILT_CYCLES == 1) begin
                        w_nextState = STABLE_HI;
                        w_riseSet   = 1'b1;
                    end else begin
                        w_nextState = CHK_HI;
                    end
                end
            end
            CHK_HI: begin
                if (!din) begin
                    w_nextState = STABLE_LO;
                    w_nextFcnt  = '0;
                end else begin
                    w_nextFcnt = w_fcntInc;
                    if (w_fcntInc == FCNT_TARGET) begin
                        w_nextState = STABLE_HI;
                        w_riseSet   = 1'b1;
                    end
                end
            end
            STABLE_HI: begin
                if (!din) begin
                    w_nextFcnt = FCNT_ONE;
                    if (FILT_CYCLES == 1) begin
                        w_nextState = STABLE_LO;
                        w_fallSet   = 1'b1;
                    end else begin
                        w_nextState = CHK_LO;
                    end
                end
            end
            CHK_LO: begin
                if (din) begin
                    w_nextState = STABLE_HI;
                    w_nextFcnt  = '0;
                end else begin
                    w_nextFcnt = w_fcntInc;
                    if (w_fcntInc == FCNT_TARGET) begin
                        w_nextState = STABLE_LO;
                        w_fallSet   = 1'b1;
                    end
                end
            end
            default: begin
                w_nextState = STABLE_LO;
                w_nextFcnt  = '0;
            end
        endcase
    end

    // Registered level and edge pulses. They update on the same edge as the
    // accepting state transition, so lvl_o and its pulse appear together.
    // The two set terms come from mutually exclusive states and can never
    // be high at once.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_lvl  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= w_riseSet;
            r_fall <= w_fallSet;
            if (w_riseSet) begin
                r_lvl <= 1'b1;
            end else if (w_fallSet) begin
                r_lvl <= 1'b0;
            end
        end
    end

    // Saturating rising-event counter. A clear that coincides with a new
    // rising edge restarts the count at one, so that event is not lost. With
    // a one-bit counter, a count of one is already all-ones and therefore
    // saturated. Once at all-ones the count holds and the sticky flag stays
    // set until the next clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
            r_sat <= 1'b0;
        end else if (clr_cnt) begin
            if (w_riseSet) begin
                r_cnt <= CNT_ONE;
                r_sat <= (CNT_W == 1);
            end else begin
                r_cnt <= '0;
                r_sat <= 1'b0;
            end
        end else if (w_riseSet && (r_cnt != CNT_MAX)) begin
            r_cnt <= w_cntInc;
            if (w_cntInc == CNT_MAX) begin
                r_sat <= 1'b1;
            end
        end
    end

    // Sticky event-pending flag. A new edge takes priority over an
    // acknowledge in the same cycle, so software never misses an event.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pending <= 1'b0;
        end else if (w_riseSet || w_fallSet) begin
            r_pending <= 1'b1;
        end else if (evt_ack) begin
            r_pending <= 1'b0;
        end
    end

    assign lvl_o         = r_lvl;
    assign rise_o        = r_rise;
    assign fall_o        = r_fall;
    assign evt_pending_o = r_pending;
    assign evt_cnt_o     = r_cnt;
    assign cnt_sat_o     = r_sat;

endmodule

// File: tb/tb_sync_level_filter.sv
// ---------------------------------------------------------------------------
// Testbench for sync_level_filter.
// Two instances share the clock and reset:
//   dut   FILT_CYCLES=4, CNT_W=3 (filtering, pending flag, saturation)
//   dutF1 FILT_CYCLES=1, CNT_W=8 (pass-through filtering)
// Expected values are hand-derived constants in a linear directed sequence.
// ---------------------------------------------------------------------------
module tb_sync_level_filter;

    logic       clk;
    logic       rstn;
    logic       din;
    logic       clrCnt;
    logic       evtAck;
    logic       lvl;
    logic       rise;
    logic       fall;
    logic       pending;
    logic [2:0] cnt;
    logic       sat;

    logic       din1;
    logic       clrCnt1;
    logic       evtAck1;
    logic       lvl1;
    logic       rise1;
    logic       fall1;
    logic       pending1;
    logic [7:0] cnt1;
    logic       sat1;

    int checks;
    int failures;

    sync_level_filter #(
        .FILT_CYCLES(4),
        .CNT_W      (3)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .din          (din),
        .clr_cnt      (clrCnt),
        .evt_ack      (evtAck),
        .lvl_o        (lvl),
        .rise_o       (rise),
        .fall_o       (fall),
        .evt_pending_o(pending),
        .evt_cnt_o    (cnt),
        .cnt_sat_o    (sat)
    );

    sync_level_filter #(
        .FILT_CYCLES(1),
        .CNT_W      (8)
    ) dutF1 (
        .clk          (clk),
        .rstn         (rstn),
        .din          (din1),
        .clr_cnt      (clrCnt1),
        .evt_ack      (evtAck1),
        .lvl_o        (lvl1),
        .rise_o       (rise1),
        .fall_o       (fall1),
        .evt_pending_o(pending1),
        .evt_cnt_o    (cnt1),
        .cnt_sat_o    (sat1)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison: counts it, and on mismatch counts and reports it.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        checkOutput("noOverlap", {31'd0, rise & fall}, 32'd0);
    endtask

    // Drive din for the main instance and run n edges.
    task automatic applyStimulus(input logic d, input int n);
        din = d;
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rstn     = 1'b0;
        din      = 1'b0;
        clrCnt   = 1'b0;
        evtAck   = 1'b0;
        din1     = 1'b0;
        clrCnt1  = 1'b0;
        evtAck1  = 1'b0;

        // Reset state
        tick();
        tick();
        checkOutput("rstLvl",     {31'd0, lvl},     32'd0);
        checkOutput("rstRise",    {31'd0, rise},    32'd0);
        checkOutput("rstFall",    {31'd0, fall},    32'd0);
        checkOutput("rstPending", {31'd0, pending}, 32'd0);
        checkOutput("rstCnt",     {29'd0, cnt},     32'd0);
        checkOutput("rstSat",     {31'd0, sat},     32'd0);
        rstn = 1'b1;
        tick();

        // First rising edge: high at edges k..k+3, accepted after edge k+3
        applyStimulus(1'b1, 3);
        checkOutput("riseEarlyLvl",  {31'd0, lvl},  32'd0);
        checkOutput("riseEarlyRise", {31'd0, rise}, 32'd0);
        applyStimulus(1'b1, 1);
        checkOutput("riseLvl",     {31'd0, lvl},     32'd1);
        checkOutput("risePulse",   {31'd0, rise},    32'd1);
        checkOutput("riseCnt",     {29'd0, cnt},     32'd1);
        checkOutput("risePending", {31'd0, pending}, 32'd1);
        applyStimulus(1'b1, 1);
        checkOutput("riseOneCycle", {31'd0, rise}, 32'd0);
        checkOutput("riseLvlHold",  {31'd0, lvl},  32'd1);

        // Counter clear with no coincident edge
        clrCnt = 1'b1;
        applyStimulus(1'b1, 1);
        clrCnt = 1'b0;
        checkOutput("clrAloneCnt",     {29'd0, cnt},     32'd0);
        checkOutput("clrAloneSat",     {31'd0, sat},     32'd0);
        checkOutput("clrKeepsPending", {31'd0, pending}, 32'd1);

        // Plain acknowledge
        evtAck = 1'b1;
        applyStimulus(1'b1, 1);
        evtAck = 1'b0;
        checkOutput("ackClears", {31'd0, pending}, 32'd0);

        // Falling edge with acknowledge in the same cycle: set wins
        applyStimulus(1'b0, 3);
        checkOutput("fallEarlyLvl", {31'd0, lvl},  32'd1);
        checkOutput("fallEarly",    {31'd0, fall}, 32'd0);
        evtAck = 1'b1;
        applyStimulus(1'b0, 1);
        checkOutput("fallPulse",     {31'd0, fall},    32'd1);
        checkOutput("fallLvl",       {31'd0, lvl},     32'd0);
        checkOutput("fallSetWins",   {31'd0, pending}, 32'd1);
        applyStimulus(1'b0, 1);
        evtAck = 1'b0;
        checkOutput("fallOneCycle",  {31'd0, fall},    32'd0);
        checkOutput("ackAfterFall",  {31'd0, pending}, 32'd0);

        // Three-cycle glitch is rejected
        applyStimulus(1'b1, 3);
        applyStimulus(1'b0, 1);
        checkOutput("glitchLvl",  {31'd0, lvl},  32'd0);
        checkOutput("glitchRise", {31'd0, rise}, 32'd0);
        checkOutput("glitchCnt",  {29'd0, cnt},  32'd0);
        // Filter restarted: a fresh run needs all four samples again
        applyStimulus(1'b1, 3);
        checkOutput("afterGlitchEarly", {31'd0, lvl}, 32'd0);
        applyStimulus(1'b1, 1);
        checkOutput("afterGlitchRise", {31'd0, rise}, 32'd1);
        checkOutput("afterGlitchCnt",  {29'd0, cnt},  32'd1);

        // Counter climbs to all-ones (7) and saturates
        for (int i = 2; i <= 7; i++) begin
            applyStimulus(1'b0, 4);
            applyStimulus(1'b1, 4);
            checkOutput("satRise", {31'd0, rise}, 32'd1);
            checkOutput("satCnt",  {29'd0, cnt},  i);
            checkOutput("satFlag", {31'd0, sat},  (i == 7) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b0, 4);
        applyStimulus(1'b1, 4);
        checkOutput("eighthRise",    {31'd0, rise}, 32'd1);
        checkOutput("eighthCntHold", {29'd0, cnt},  32'd7);
        checkOutput("eighthSat",     {31'd0, sat},  32'd1);

        // Clear coinciding with a rise keeps the new event
        applyStimulus(1'b0, 4);
        applyStimulus(1'b1, 3);
        clrCnt = 1'b1;
        applyStimulus(1'b1, 1);
        clrCnt = 1'b0;
        checkOutput("clrRiseRise", {31'd0, rise}, 32'd1);
        checkOutput("clrRiseCnt",  {29'd0, cnt},  32'd1);
        checkOutput("clrRiseSat",  {31'd0, sat},  32'd0);

        // Go low so pending is set, then reset mid check run (fcnt=2)
        applyStimulus(1'b0, 4);
        checkOutput("preRstFall",    {31'd0, fall},    32'd1);
        checkOutput("preRstPending", {31'd0, pending}, 32'd1);
        applyStimulus(1'b1, 2);
        checkOutput("midChkLvl", {31'd0, lvl}, 32'd0);
        rstn = 1'b0;
        #1;
        checkOutput("asyncRstPending", {31'd0, pending}, 32'd0);
        checkOutput("asyncRstCnt",     {29'd0, cnt},     32'd0);
        checkOutput("asyncRstFall",    {31'd0, fall},    32'd0);
        checkOutput("asyncRstLvl",     {31'd0, lvl},     32'd0);
        applyStimulus(1'b1, 2);
        rstn = 1'b1;
        applyStimulus(1'b1, 3);
        checkOutput("postRstEarly", {31'd0, rise}, 32'd0);
        applyStimulus(1'b1, 1);
        checkOutput("postRstRise", {31'd0, rise}, 32'd1);
        checkOutput("postRstLvl",  {31'd0, lvl},  32'd1);
        checkOutput("postRstCnt",  {29'd0, cnt},  32'd1);

        // FILT_CYCLES=1: level follows one cycle after each sample change
        for (int rep = 0; rep < 2; rep++) begin
            din1 = 1'b1;
            tick();
            checkOutput("f1RiseLvl",  {31'd0, lvl1},  32'd1);
            checkOutput("f1Rise",     {31'd0, rise1}, 32'd1);
            checkOutput("f1RiseFall", {31'd0, fall1}, 32'd0);
            tick();
            checkOutput("f1HoldHi",   {31'd0, lvl1},  32'd1);
            checkOutput("f1RiseOnce", {31'd0, rise1}, 32'd0);
            din1 = 1'b0;
            tick();
            checkOutput("f1FallLvl",  {31'd0, lvl1},  32'd0);
            checkOutput("f1Fall",     {31'd0, fall1}, 32'd1);
            checkOutput("f1FallRise", {31'd0, rise1}, 32'd0);
            tick();
            checkOutput("f1FallOnce", {31'd0, fall1}, 32'd0);
        end
        checkOutput("f1Cnt", {24'd0, cnt1}, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
